branch_predict_unit: RTL

- Parametrised successor to the single-cycle branch controller.
- Resolves RISC-V conditional branches in EX using the same fun3/zero/less rules.
- Adds a dynamic predictor for fetch: a direct-mapped table of 2-bit saturating counters indexed by PC.
- Raises a flush/redirect on misprediction and keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predict_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//
// Resolves RISC-V conditional branches in the EX stage and predicts branch
// direction for the fetch stage. Prediction comes from a direct-mapped
// table of 2-bit saturating counters indexed by PC, with no tags. On a
// misprediction the unit raises a flush and supplies the correct next PC.
// Two saturating counters record resolved branches and mispredictions.
//
// Parameters
//   XLEN        PC / target width
//   INDEX_BITS  log2 of table depth; index = pc[INDEX_BITS+1:2]
//   INIT_STATE  counter value loaded into every entry at reset
//   CNT_W       width of the statistics counters
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset
//   if_pc             PC of the instruction in fetch
//   if_pred_taken     prediction for if_pc (combinational, pre-edge table value)
//   ex_valid          EX holds a real instruction
//   ex_branch         EX instruction is a conditional branch
//   ex_fun3           branch funct3
//   ex_zero           ALU zero flag (rs1 == rs2)
//   ex_less           ALU less flag (signedness chosen by the ALU)
//   ex_pc             PC of the EX instruction
//   ex_target         computed branch target
//   ex_pred_taken     prediction that was made for this instruction at fetch
//   ex_taken          resolved direction
//   flush             misprediction: squash younger IF/ID instructions
//   redirect_pc       correct next PC, meaningful while flush = 1
//   branch_count      number of resolved branches (saturating)
//   mispredict_count  number of mispredictions (saturating)
// -----------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_fun3,
  input  logic             ex_zero,
  input  logic             ex_less,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             ex_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  // RISC-V branch funct3 encodings; 010 and 011 are not branches.
  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  // The MSB is the predicted direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] cur,
                                          input logic       taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != 2'b11) nxt = cur + 2'd1;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0][1:0] bht_q, bht_d;
  logic [CNT_W-1:0]      branch_count_q, branch_count_d;
  logic [CNT_W-1:0]      mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;

  logic                  dir;
  logic                  fun3_ok;
  logic                  res;
  logic                  mispred;
  logic [XLEN-1:0]       seq_pc;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];

  // Byte-offset bits and the bits above the index never reach the table;
  // PCs differing only there alias to the same entry by design.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[1:0], if_pc[XLEN-1:INDEX_BITS+2]};

  // ---------------------------------------------------------------------------
  // Prediction: reads the registered table, so a same-edge update to the
  // same entry is not bypassed.
  // ---------------------------------------------------------------------------
  assign if_pred_taken = bht_q[if_idx][1];

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    dir     = 1'b0;
    fun3_ok = 1'b1;
    case (ex_fun3)
      F_BEQ:          dir = ex_zero;
      F_BNE:          dir = !ex_zero;
      F_BLT, F_BLTU:  dir = ex_less;
      F_BGE, F_BGEU:  dir = !ex_less;
      default:        fun3_ok = 1'b0;
    endcase
  end

  assign res      = ex_valid & ex_branch & fun3_ok;
  assign ex_taken = res & dir;
  assign mispred  = res & (ex_taken != ex_pred_taken);
  assign flush    = mispred;

  // Fall-through address wraps modulo 2^XLEN.
  assign seq_pc      = ex_pc + PC_STEP;
  assign redirect_pc = ex_taken ? ex_target : seq_pc;

  // ---------------------------------------------------------------------------
  // Next-state: one table entry and the statistics counters
  // ---------------------------------------------------------------------------
  always_comb begin
    bht_d = bht_q;
    if (res) begin
      bht_d[ex_idx] = ctr_next(bht_q[ex_idx], ex_taken);
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res && (branch_count_q != CNT_MAX)) begin
      branch_count_d = branch_count_q + CNT_ONE;
    end
    if (mispred && (mispredict_count_q != CNT_MAX)) begin
      mispredict_count_d = mispredict_count_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the table is built from flops rather than RAM so every entry can be
  // forced to INIT_STATE by the asynchronous reset; predictions must be
  // well-defined from the first fetch after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // pre-edge values regardless of statement order.
      bht_q              <= {DEPTH{INIT_STATE}};
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
